// File: rtl/seq_chunk_comparator_if.sv
// -----------------------------------------------------------------------------
// seq_chunk_comparator_if
// Start handshake and result bus of the sequential chunk comparator.
//
// Handshake: a compare is accepted on a rising clk edge where start_valid and
// start_ready are both high. start_ready is high whenever the comparator is
// idle (including the cycle done is high). The requester may drop or change
// start_valid and operands freely after the accepting edge; they are ignored
// until the next time start_ready is high.
//
// Signals (W = N*CHUNKS, CW = $clog2(CHUNKS+1)):
//   start_valid   master->slave  request a compare
//   start_ready   slave->master  comparator idle, able to accept
//   a, b          master->slave  W-bit operands, sampled on accept
//   signed_mode   master->slave  1 = two's-complement compare
//   Iagtb/Iaeqb/Ialtb  master->slave  cascade inputs used when A==B
//   busy          slave->master  compare in progress
//   done          slave->master  one-cycle pulse, result valid
//   Oagtb/Oaeqb/Oaltb  slave->master  one-hot result, held
//   cmp_cycles    slave->master  chunks examined for the held result
// -----------------------------------------------------------------------------
interface seq_chunk_comparator_if #(
   parameter int N      = 4,
   parameter int CHUNKS = 4
);
   localparam int W  = N * CHUNKS;
   localparam int CW = $clog2(CHUNKS + 1);

   logic          start_valid;
   logic          start_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          signed_mode;
   logic          Iagtb;
   logic          Iaeqb;
   logic          Ialtb;
   logic          busy;
   logic          done;
   logic          Oagtb;
   logic          Oaeqb;
   logic          Oaltb;
   logic [CW-1:0] cmp_cycles;

   modport master (
      output start_valid, a, b, signed_mode, Iagtb, Iaeqb, Ialtb,
      input  start_ready, busy, done, Oagtb, Oaeqb, Oaltb, cmp_cycles
   );

   modport slave (
      input  start_valid, a, b, signed_mode, Iagtb, Iaeqb, Ialtb,
      output start_ready, busy, done, Oagtb, Oaeqb, Oaltb, cmp_cycles
   );
endinterface

// File: rtl/seq_chunk_comparator.sv
// -----------------------------------------------------------------------------
// seq_chunk_comparator
// Multi-cycle magnitude comparator for W = N*CHUNKS bit operands. One N-bit
// chunk is compared per clock, most significant chunk first. The first unequal
// chunk decides the result; if every chunk is equal the latched cascade inputs
// decide (Iagtb, then Ialtb, otherwise equal).
//
// Build option: define SEQ_CMP_EARLY_EXIT_EN to finish on the edge that finds
// the first unequal chunk (cmp_cycles = chunks examined). Without it every
// chunk is always walked and cmp_cycles = CHUNKS. Results are identical.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cmp          seq_chunk_comparator_if.slave (handshake, operands, result)
//   dbg_state_o  current FSM state (0 = IDLE, 1 = CMP)
// -----------------------------------------------------------------------------
module seq_chunk_comparator #(
   parameter int N      = 4,
   parameter int CHUNKS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seq_chunk_comparator_if.slave   cmp,
   output logic                    dbg_state_o
);
   localparam int W  = N * CHUNKS;
   localparam int CW = $clog2(CHUNKS + 1);
   // XOR-ing the sign bit turns a two's-complement compare into an unsigned one.
   localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

   typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

   state_t        state_q;
   logic [W-1:0]  a_q, b_q;        // shifted left by N each CMP cycle
   logic          sgn_q;
   logic          cgt_q, clt_q;    // latched cascade inputs
   logic [CW-1:0] cnt_q;           // chunks already examined
   logic          dec_q;           // an unequal chunk has been seen
   logic          dgt_q, dlt_q;    // verdict of that first unequal chunk
   logic          gt_q, eq_q, lt_q, done_q;
   logic [CW-1:0] cc_q;

   logic [N-1:0]  ca, cb, flip;
   logic          chunk_gt, chunk_lt, last_chunk, first_diff;
   logic          res_gt_d, res_lt_d, finish_d;

   always_comb begin
      // Only the most significant chunk (first one examined) carries the sign.
      flip       = (sgn_q && (cnt_q == '0)) ? MSB_MASK : '0;
      ca         = a_q[W-1 -: N] ^ flip;
      cb         = b_q[W-1 -: N] ^ flip;
      chunk_gt   = (ca > cb);
      chunk_lt   = (ca < cb);
      last_chunk = (cnt_q == CW'(CHUNKS - 1));
      first_diff = !dec_q && (chunk_gt || chunk_lt);
      res_gt_d   = dec_q ? dgt_q : (first_diff ? chunk_gt : cgt_q);
      res_lt_d   = dec_q ? dlt_q : (first_diff ? chunk_lt : (!cgt_q && clt_q));
`ifdef SEQ_CMP_EARLY_EXIT_EN
      finish_d   = last_chunk || first_diff;
`else
      finish_d   = last_chunk;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         cgt_q   <= 1'b0;
         clt_q   <= 1'b0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         dgt_q   <= 1'b0;
         dlt_q   <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         done_q  <= 1'b0;
         cc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (cmp.start_valid) begin
                  a_q     <= cmp.a;
                  b_q     <= cmp.b;
                  sgn_q   <= cmp.signed_mode;
                  cgt_q   <= cmp.Iagtb;
                  clt_q   <= cmp.Ialtb;
                  cnt_q   <= '0;
                  dec_q   <= 1'b0;
                  state_q <= CMP;
               end
            end
            CMP: begin
               a_q    <= a_q << N;
               b_q    <= b_q << N;
               cnt_q  <= cnt_q + CW'(1);
               done_q <= finish_d;
               if (first_diff) begin
                  dec_q <= 1'b1;
                  dgt_q <= chunk_gt;
                  dlt_q <= chunk_lt;
               end
               if (finish_d) begin
                  gt_q    <= res_gt_d;
                  lt_q    <= res_lt_d;
                  eq_q    <= !res_gt_d && !res_lt_d;
                  cc_q    <= cnt_q + CW'(1);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmp.start_ready = (state_q == IDLE);
   assign cmp.busy        = (state_q == CMP);
   assign cmp.done        = done_q;
   assign cmp.Oagtb       = gt_q;
   assign cmp.Oaeqb       = eq_q;
   assign cmp.Oaltb       = lt_q;
   assign cmp.cmp_cycles  = cc_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_seq_chunk_comparator.sv
module tb_seq_chunk_comparator;
   localparam int N      = 4;
   localparam int CHUNKS = 4;
   localparam int W      = N * CHUNKS;
   localparam int CW     = $clog2(CHUNKS + 1);
`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic dbg_state;
   int   vectors;
   int   miscompares;

   seq_chunk_comparator_if #(.N(N), .CHUNKS(CHUNKS)) cif ();

   seq_chunk_comparator #(.N(N), .CHUNKS(CHUNKS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmp         (cif.slave),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected chunks-examined / latency for a first unequal chunk at j
   function automatic int exp_j(input int j);
      return EE ? j : CHUNKS;
   endfunction

   // ---------------- driver ----------------
   // Accepts one compare, scrambles operands afterwards, and reports the
   // number of edges from accept to done, the result and whether done was
   // still high one cycle later.
   task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sm, input logic cg, input logic ce,
                          input logic cl, output int lat,
                          output logic [2:0] res, output logic [CW-1:0] cc,
                          output logic done2);
      @(negedge clk);
      cif.a = av; cif.b = bv; cif.signed_mode = sm;
      cif.Iagtb = cg; cif.Iaeqb = ce; cif.Ialtb = cl;
      cif.start_valid = 1'b1;
      @(posedge clk); #1;
      cif.start_valid = 1'b0;
      cif.a = '0; cif.b = '1; cif.signed_mode = ~sm;
      cif.Iagtb = ~cg; cif.Ialtb = ~cl;
      lat = 0;
      while (!cif.done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      res = {cif.Oagtb, cif.Oaeqb, cif.Oaltb};
      cc  = cif.cmp_cycles;
      @(posedge clk); #1;
      done2 = cif.done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({cif.start_ready, cif.busy, cif.done, dbg_state} !== 4'b1000) begin
         $display("FAIL reset_ctrl: got ready/busy/done/state=%b want 1000",
                  {cif.start_ready, cif.busy, cif.done, dbg_state});
         miscompares++;
      end
      vectors++;
      if ({cif.Oagtb, cif.Oaeqb, cif.Oaltb, cif.cmp_cycles} !== {3'b000, CW'(0)}) begin
         $display("FAIL reset_result: got gt/eq/lt=%b cc=%0d want 000 cc=0",
                  {cif.Oagtb, cif.Oaeqb, cif.Oaltb}, cif.cmp_cycles);
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sm;
      logic [2:0]   casc;   // {Iagtb, Iaeqb, Ialtb}
      logic [2:0]   res;    // {gt, eq, lt}
      int           j;      // first unequal chunk position (CHUNKS if none)
      string        name;
   } vec_t;

   task automatic test_directed;
      vec_t tbl[9];
      int          lat;
      logic [2:0]  res;
      logic [CW-1:0] cc;
      logic        d2;
      tbl[0] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 3'b010, 4, "eq_casc_eq"};
      tbl[1] = '{16'h8000, 16'h7FFF, 1'b0, 3'b000, 3'b100, 1, "msb_unsigned"};
      tbl[2] = '{16'h8000, 16'h7FFF, 1'b1, 3'b000, 3'b001, 1, "msb_signed"};
      tbl[3] = '{16'h0800, 16'h07FF, 1'b1, 3'b000, 3'b100, 2, "lower_unsigned"};
      tbl[4] = '{16'h12F0, 16'h12E0, 1'b0, 3'b000, 3'b100, 3, "chunk1_gt"};
      tbl[5] = '{16'h12E0, 16'h12F0, 1'b0, 3'b000, 3'b001, 3, "chunk1_lt"};
      tbl[6] = '{16'h1234, 16'h1234, 1'b0, 3'b101, 3'b100, 4, "casc_gt_wins"};
      tbl[7] = '{16'h5A5A, 16'h5A5A, 1'b0, 3'b000, 3'b010, 4, "casc_zero"};
      tbl[8] = '{16'hFFFF, 16'h8000, 1'b1, 3'b000, 3'b100, 1, "neg_signed"};
      for (int i = 0; i < 9; i++) begin
         run_cmp(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].casc[2], tbl[i].casc[1],
                 tbl[i].casc[0], lat, res, cc, d2);
         vectors++;
         if (res !== tbl[i].res) begin
            $display("FAIL %s result: got gt/eq/lt=%b want %b", tbl[i].name, res, tbl[i].res);
            miscompares++;
         end
         vectors++;
         if (lat !== exp_j(tbl[i].j)) begin
            $display("FAIL %s latency: got %0d want %0d", tbl[i].name, lat, exp_j(tbl[i].j));
            miscompares++;
         end
         vectors++;
         if (cc !== CW'(exp_j(tbl[i].j))) begin
            $display("FAIL %s cmp_cycles: got %0d want %0d", tbl[i].name, cc, exp_j(tbl[i].j));
            miscompares++;
         end
         vectors++;
         if (d2 !== 1'b0) begin
            $display("FAIL %s done_width: got done=%b one cycle later want 0", tbl[i].name, d2);
            miscompares++;
         end
      end
   endtask

   task automatic test_reset_mid;
      int            lat;
      logic [2:0]    res;
      logic [CW-1:0] cc;
      logic          d2;
      logic          seen;
      @(negedge clk);
      cif.a = 16'h1234; cif.b = 16'h1234; cif.signed_mode = 1'b0;
      cif.Iagtb = 1'b0; cif.Iaeqb = 1'b1; cif.Ialtb = 1'b0;
      cif.start_valid = 1'b1;
      @(posedge clk); #1;          // E0 accept
      cif.start_valid = 1'b0;
      @(posedge clk);              // E1
      @(posedge clk); #1;          // E2
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({cif.start_ready, cif.busy, cif.done, dbg_state} !== 4'b1000) begin
         $display("FAIL midreset_ctrl: got ready/busy/done/state=%b want 1000",
                  {cif.start_ready, cif.busy, cif.done, dbg_state});
         miscompares++;
      end
      vectors++;
      if ({cif.Oagtb, cif.Oaeqb, cif.Oaltb, cif.cmp_cycles} !== {3'b000, CW'(0)}) begin
         $display("FAIL midreset_result: got gt/eq/lt=%b cc=%0d want 000 cc=0",
                  {cif.Oagtb, cif.Oaeqb, cif.Oaltb}, cif.cmp_cycles);
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (cif.done || cif.busy) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         $display("FAIL midreset_no_done: got done/busy activity=%b want 0", seen);
         miscompares++;
      end
      run_cmp(16'h12F0, 16'h12E0, 1'b0, 1'b0, 1'b0, 1'b0, lat, res, cc, d2);
      vectors++;
      if (res !== 3'b100 || lat !== exp_j(3) || cc !== CW'(exp_j(3))) begin
         $display("FAIL midreset_fresh: got res=%b lat=%0d cc=%0d want res=100 lat=%0d cc=%0d",
                  res, lat, cc, exp_j(3), exp_j(3));
         miscompares++;
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] pa[2];
      logic [W-1:0] pb[2];
      logic [2:0]   pres[2];
      int           pj[2];
      int           lat;
      pa[0] = 16'h8000; pb[0] = 16'h7FFF; pres[0] = 3'b100; pj[0] = 1;
      pa[1] = 16'h1234; pb[1] = 16'h1234; pres[1] = 3'b010; pj[1] = 4;
      @(negedge clk);
      cif.a = pa[0]; cif.b = pb[0]; cif.signed_mode = 1'b0;
      cif.Iagtb = 1'b0; cif.Iaeqb = 1'b0; cif.Ialtb = 1'b0;
      cif.start_valid = 1'b1;
      @(posedge clk); #1;          // first accept
      for (int t = 0; t < 4; t++) begin
         if (t > 0) begin
            vectors++;
            if ({cif.Oagtb, cif.Oaeqb, cif.Oaltb} !== pres[(t-1)%2]) begin
               $display("FAIL b2b_held[%0d]: got %b want %b", t,
                        {cif.Oagtb, cif.Oaeqb, cif.Oaltb}, pres[(t-1)%2]);
               miscompares++;
            end
         end
         cif.a = '0; cif.b = '1;   // ignored: already accepted
         lat = 0;
         while (!cif.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         vectors++;
         if ({cif.Oagtb, cif.Oaeqb, cif.Oaltb} !== pres[t%2] || lat !== exp_j(pj[t%2])
             || cif.cmp_cycles !== CW'(exp_j(pj[t%2])) || cif.start_ready !== 1'b1) begin
            $display("FAIL b2b_result[%0d]: got res=%b lat=%0d cc=%0d ready=%b want res=%b lat=%0d cc=%0d ready=1",
                     t, {cif.Oagtb, cif.Oaeqb, cif.Oaltb}, lat, cif.cmp_cycles,
                     cif.start_ready, pres[t%2], exp_j(pj[t%2]), exp_j(pj[t%2]));
            miscompares++;
         end
         if (t == 3) cif.start_valid = 1'b0;
         cif.a = pa[(t+1)%2]; cif.b = pb[(t+1)%2];
         @(posedge clk); #1;       // accept of next op, or idle
      end
      vectors++;
      if ({cif.busy, cif.done, cif.start_ready} !== 3'b001) begin
         $display("FAIL b2b_idle: got busy/done/ready=%b want 001",
                  {cif.busy, cif.done, cif.start_ready});
         miscompares++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      vectors = 0;
      miscompares = 0;
      cif.start_valid = 1'b0;
      cif.a = '0; cif.b = '0; cif.signed_mode = 1'b0;
      cif.Iagtb = 1'b0; cif.Iaeqb = 1'b0; cif.Ialtb = 1'b0;
      test_reset;
      test_directed;
      test_reset_mid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/seq_chunk_comparator.md
Name: seq_chunk_comparator

Overview:
- Multi-cycle magnitude comparator for wide operands (N*CHUNKS bits).
- Compares one N-bit chunk per clock, most significant chunk first.
- Supports cascade inputs, an unsigned/signed mode, and a valid/ready start handshake.
- Serves as the sequential successor to the combinational cascadable N-bit comparator. Used where operands are too wide for a single-cycle compare tree.

Parameters:
- N, 4, chunk width in bits (>=1).
- CHUNKS, 4, number of chunks (>=1). Operand width W = N*CHUNKS.
- CW, $clog2(CHUNKS+1), width of cmp_cycles (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request a compare.
- start_ready  output  1  block idle, able to accept; combinational from state.
- a  input  W  operand A, sampled on accept.
- b  input  W  operand B, sampled on accept.
- signed_mode  input  1  1 = two's-complement compare; sampled on accept.
- Iagtb  input  1  cascade in "greater", sampled on accept.
- Iaeqb  input  1  cascade in "equal", sampled on accept.
- Ialtb  input  1  cascade in "less", sampled on accept.
- busy  output  1  compare in progress.
- done  output  1  one-cycle pulse, result valid.
- Oagtb  output  1  result A>B, held.
- Oaeqb  output  1  result A==B, held.
- Oaltb  output  1  result A<B, held.
- cmp_cycles  output  CW  number of chunks examined for the current result, held.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, Oagtb, Oaeqb, Oaltb all 0; cmp_cycles=0.
  - start_ready=1 as soon as reset is applied.
- States are IDLE and CMP. start_ready = (state==IDLE); busy = (state==CMP).
- Accept:
  - Occurs at an edge with start_valid & start_ready.
  - Latches a, b, signed_mode and the cascade inputs; sets idx=CHUNKS-1; state goes to CMP.
  - Input changes after accept are ignored.
  - start_valid during CMP is ignored.
- CMP, one chunk per edge (chunk idx = bits [idx*N+N-1 : idx*N]):
  - Chunk CHUNKS-1 is compared signed when signed_mode=1; all other chunks are always unsigned.
  - The first unequal chunk decides the result. Later chunks never override it.
  - If all chunks are equal, the result comes from the latched cascade inputs:
    - Iagtb=1 gives gt; else Ialtb=1 gives lt; else eq.
    - An all-zero cascade yields eq.
- Decision edge:
  - Registers exactly one-hot Oagtb/Oaeqb/Oaltb and cmp_cycles.
  - done=1 for the following cycle; state returns to IDLE.
- Back-to-back: start_ready=1 during the done cycle, so a new accept in that cycle is legal. The previous result stays held until the next decision edge.
- Latency: accept at edge E0; decision at E_CHUNKS; done high for the cycle after E_CHUNKS (see feature for early exit).
- CHUNKS=1: decision at E1, no special casing.
- Reset mid-CMP: operation abandoned, no done pulse, outputs cleared; the next accept behaves normally.

Optional Feature:
- Macro: SEQ_CMP_EARLY_EXIT_EN.
- Defined:
  - Decision occurs at the edge evaluating the first unequal chunk, E_j where j = chunks examined.
  - cmp_cycles=j.
  - If all chunks are equal, decision at E_CHUNKS.
- Undefined:
  - All CHUNKS chunks are always evaluated; decision always at E_CHUNKS; cmp_cycles=CHUNKS.
- Result values are identical in both builds; only timing and cmp_cycles differ.

Test Plan:
- (N=4, CHUNKS=4) a=16'h1234, b=16'h1234, Iaeqb=1 -> Oaeqb=1, done the cycle after E4, cmp_cycles=4 (both builds).
- a=16'h8000, b=16'h7FFF, signed_mode=0 -> Oagtb=1. EARLY_EXIT: done after E1, cmp_cycles=1. Otherwise done after E4, cmp_cycles=4.
- Same operands with signed_mode=1 -> Oaltb=1. Repeat with a=16'h0800, b=16'h07FF, signed_mode=1 -> Oagtb=1 (lower chunks unsigned).
- a=16'h12F0, b=16'h12E0 -> Oagtb=1; EARLY_EXIT cmp_cycles=3. Equal operands with Iagtb=Ialtb=1 -> Oagtb=1. Equal operands with all cascade inputs 0 -> Oaeqb=1.
- Reset pulsed at E2 of a compare -> outputs 0, no done, start_ready=1 during reset. A fresh compare afterwards completes correctly.
- start_valid held high continuously with alternating operands -> new accept in each done cycle. Results held between done pulses. Mid-compare changes to a/b do not alter the result.
